imem_responder: RTL

- Instruction-memory responder on the fetch-side memory interface: the far end of the fetch stage's request/we_re/mask/address handshake.
- Latches one request at a time and services it from an internal word array after a programmable number of wait states.
- Returns read data with a one-cycle valid pulse.
- Also accepts byte-masked writes, used for program preload, and supports cancelling an in-flight read on a pipeline flush.

---
 rtl/imem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: one outstanding access at a time, serviced
// from an internal word array after WAIT_STATES idle cycles; byte-masked writes for preload.
//
//  state | meaning
//  IDLE  | ready; latches a request (reads refused while flush is high)
//  WAIT  | counting down wait states; a read here is cancelled by flush
//  RESP  | completes the access on its closing edge; valid follows for one cycle
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] instruction_fetch,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;

  logic [29:0]   idx_q;
  logic          we_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic          in_range;
  logic          accept;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  // a read offered together with flush is refused; writes are never cancelled
  assign accept   = (state == ST_IDLE) && request && (we_re || !flush);
  assign in_range = ({2'b00, idx_q} < 32'(DEPTH_WORDS));
  assign widx     = idx_q[AW-1:0];
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (flush && !we_q) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_IDLE;
        end else if (cnt <= 4'd1) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= 30'd0;
      we_q    <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      idx_q   <= address[31:2];
      we_q    <= we_re;
      mask_q  <= mask;
      wdata_q <= wdata;
    end
  end

  // valid is registered off RESP, so it lands in the IDLE cycle that can take the next request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid             <= 1'b0;
      err               <= 1'b0;
      instruction_fetch <= NOP_WORD;
    end else begin
      valid <= (state == ST_RESP);
      if (state == ST_RESP) begin
        if (!in_range) err <= 1'b1;
        if (!we_q) instruction_fetch <= (flush || !in_range) ? NOP_WORD : mem[widx];
      end
    end
  end

  // array has no reset; reset forces IDLE so an abandoned write never reaches this edge
  always_ff @(posedge clk) begin
    if (state == ST_RESP && we_q && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
